// File: rtl/alarm_pkg.sv
// Shared types, widths and the snooze-target helper for the alarm bank.
package alarm_pkg;

  localparam int unsigned HOUR_W        = 5;
  localparam int unsigned MIN_W         = 6;
  localparam int unsigned SEC_W         = 6;
  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned MINS_PER_HOUR = 60;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZED  = 2'd3
  } alarm_state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
  } hm_t;

  // Live time plus add_min minutes, carrying into the hour and wrapping at midnight.
  function automatic hm_t snooze_target(input logic [HOUR_W-1:0] h,
                                        input logic [MIN_W-1:0]  m,
                                        input int unsigned       add_min);
    int unsigned mm;
    int unsigned hh;
    hm_t         r;
    mm = 32'(m) + add_min;
    hh = 32'(h);
    if (mm >= MINS_PER_HOUR) begin
      mm = mm - MINS_PER_HOUR;
      hh = hh + 1;
    end
    if (hh >= HOURS_PER_DAY) begin
      hh = 0;
    end
    r.hour   = hh[HOUR_W-1:0];
    r.minute = mm[MIN_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/alarm_bank_channel.sv
// One alarm channel: state machine, programmed time, snooze target and counters.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic [HOUR_W-1:0] hour_i,
  input  logic [MIN_W-1:0]  minute_i,
  input  logic              toggle_i,
  input  logic              snooze_i,
  input  logic              stop_i,
  input  logic              wr_i,
  input  logic [HOUR_W-1:0] wr_hour_i,
  input  logic [MIN_W-1:0]  wr_min_i,
  output logic              ringing_o,
  output logic              enabled_o
);

  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);
  localparam logic [7:0] SNZ_MAX   = 8'(MAX_SNOOZE);

  alarm_state_t state_q, state_d;
  hm_t          set_q, set_d;
  hm_t          tgt_q, tgt_d;
  logic [7:0]   ring_cnt_q, ring_cnt_d;
  logic [7:0]   snz_cnt_q, snz_cnt_d;
  logic         match_q, match_d;
  logic         tmatch_q, tmatch_d;
  logic         match_edge, tmatch_edge;

  // Next-state logic: toggle outranks write, write outranks normal sequencing.
  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    tgt_d       = tgt_q;
    ring_cnt_d  = ring_cnt_q;
    snz_cnt_d   = snz_cnt_q;
    match_d     = (hour_i == set_q.hour) && (minute_i == set_q.minute);
    tmatch_d    = (hour_i == tgt_q.hour) && (minute_i == tgt_q.minute);
    match_edge  = match_d && !match_q;
    tmatch_edge = tmatch_d && !tmatch_q;

    if (toggle_i) begin
      state_d    = (state_q == ST_DISABLED) ? ST_ARMED : ST_DISABLED;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else if (wr_i) begin
      if (state_q != ST_DISABLED) begin
        state_d = ST_ARMED;
      end
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          // A stop coinciding with the match edge suppresses the ring; match_q
          // then keeps the rest of the minute from retriggering.
          if (match_edge && !stop_i) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
          end
        end
        ST_RINGING: begin
          if (stop_i) begin
            state_d = ST_ARMED;
          end else if (snooze_i) begin
            if (snz_cnt_q < SNZ_MAX) begin
              state_d   = ST_SNOOZED;
              snz_cnt_d = snz_cnt_q + 8'd1;
              tgt_d     = snooze_target(hour_i, minute_i, SNOOZE_MIN);
            end else begin
              state_d = ST_ARMED;
            end
          end else if (tick_i) begin
            if (ring_cnt_q == RING_LAST) begin
              state_d = ST_ARMED;
            end else begin
              ring_cnt_d = ring_cnt_q + 8'd1;
            end
          end
        end
        ST_SNOOZED: begin
          if (stop_i) begin
            state_d = ST_ARMED;
          end else if (tmatch_edge) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        default: state_d = state_q;
      endcase
    end

    if (wr_i) begin
      set_d.hour   = wr_hour_i;
      set_d.minute = wr_min_i;
    end
  end

  // Channel registers with asynchronous reset to disabled, 00:00, counters clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DISABLED;
      set_q      <= '0;
      tgt_q      <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      match_q    <= 1'b0;
      tmatch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      tgt_q      <= tgt_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      match_q    <= match_d;
      tmatch_q   <= tmatch_d;
    end
  end

  assign ringing_o = (state_q == ST_RINGING);
  assign enabled_o = (state_q != ST_DISABLED);

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm controller: NUM_ALARMS independent channels sharing snooze/stop.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_1hz,
  input  logic [HOUR_W-1:0]     hour,
  input  logic [MIN_W-1:0]      minute,
  input  logic [SEC_W-1:0]      second,
  input  logic                  wr_en,
  input  logic [2:0]            wr_idx,
  input  logic [HOUR_W-1:0]     wr_hour,
  input  logic [MIN_W-1:0]      wr_min,
  input  logic [NUM_ALARMS-1:0] toggle_i,
  input  logic                  snooze_i,
  input  logic                  stop_i,
  output logic [NUM_ALARMS-1:0] ringing_o,
  output logic [NUM_ALARMS-1:0] enabled_o,
  output logic                  alarm_o
);

  // Seconds only matter through tick_1hz; the live value is not compared.
  logic unused_second;
  assign unused_second = ^second;

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_ch
    logic wr_k;
    // Out-of-range indices never equal any k, so such writes are dropped.
    assign wr_k = wr_en && (wr_idx == 3'(k));

    alarm_channel #(
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_SEC  (RING_SEC),
      .MAX_SNOOZE(MAX_SNOOZE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick_1hz),
      .hour_i   (hour),
      .minute_i (minute),
      .toggle_i (toggle_i[k]),
      .snooze_i (snooze_i),
      .stop_i   (stop_i),
      .wr_i     (wr_k),
      .wr_hour_i(wr_hour),
      .wr_min_i (wr_min),
      .ringing_o(ringing_o[k]),
      .enabled_o(enabled_o[k])
    );
  end

  assign alarm_o = |ringing_o;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank with a minute-of-day reference model.
module tb_alarm_bank;

  localparam int N    = 4;
  localparam int SNZ  = 5;
  localparam int RSEC = 60;
  localparam int MAXS = 3;

  logic         clk;
  logic         rst_n;
  logic         tick_1hz;
  logic [4:0]   hour;
  logic [5:0]   minute;
  logic [5:0]   second;
  logic         wr_en;
  logic [2:0]   wr_idx;
  logic [4:0]   wr_hour;
  logic [5:0]   wr_min;
  logic [N-1:0] toggle_i;
  logic         snooze_i;
  logic         stop_i;
  logic [N-1:0] ringing_o;
  logic [N-1:0] enabled_o;
  logic         alarm_o;

  alarm_bank #(
    .NUM_ALARMS(N),
    .SNOOZE_MIN(SNZ),
    .RING_SEC  (RSEC),
    .MAX_SNOOZE(MAXS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1hz (tick_1hz),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_hour  (wr_hour),
    .wr_min   (wr_min),
    .toggle_i (toggle_i),
    .snooze_i (snooze_i),
    .stop_i   (stop_i),
    .ringing_o(ringing_o),
    .enabled_o(enabled_o),
    .alarm_o  (alarm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef enum int {M_OFF, M_ARM, M_RING, M_SNZ} mmode_t;
  mmode_t mode [N];
  int     set_t[N];   // programmed minute of day
  int     tgt_t[N];   // snooze target minute of day
  int     rsec [N];
  int     nsnz [N];
  bit     phit [N];
  bit     pthit[N];

  // stimulus variables (applied at the next negedge)
  int       tod;      // seconds of day
  bit       tk, snz, stp, we;
  int       widx, wh, wm;
  logic [N-1:0] tog;

  logic [2*N:0] sbq[$];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mode[k] = M_OFF; set_t[k] = 0; tgt_t[k] = 0;
      rsec[k] = 0; nsnz[k] = 0; phit[k] = 0; pthit[k] = 0;
    end
  endtask

  task automatic model_step();
    int cur;
    bit hit, thit, rise, trise, wr_here;
    cur = tod / 60;
    for (int k = 0; k < N; k++) begin
      hit     = (cur == set_t[k]);
      thit    = (cur == tgt_t[k]);
      rise    = hit && !phit[k];
      trise   = thit && !pthit[k];
      wr_here = we && (widx == k);
      if (tog[k]) begin
        mode[k] = (mode[k] == M_OFF) ? M_ARM : M_OFF;
        rsec[k] = 0; nsnz[k] = 0;
      end else if (wr_here) begin
        if (mode[k] != M_OFF) mode[k] = M_ARM;
        rsec[k] = 0; nsnz[k] = 0;
      end else begin
        case (mode[k])
          M_ARM: if (rise && !stp) begin
            mode[k] = M_RING; rsec[k] = 0; nsnz[k] = 0;
          end
          M_RING: begin
            if (stp) mode[k] = M_ARM;
            else if (snz) begin
              if (nsnz[k] < MAXS) begin
                mode[k]  = M_SNZ;
                nsnz[k]  = nsnz[k] + 1;
                tgt_t[k] = (cur + SNZ) % 1440;
              end else mode[k] = M_ARM;
            end else if (tk) begin
              rsec[k] = rsec[k] + 1;
              if (rsec[k] >= RSEC) mode[k] = M_ARM;
            end
          end
          M_SNZ: begin
            if (stp) mode[k] = M_ARM;
            else if (trise) begin
              mode[k] = M_RING; rsec[k] = 0;
            end
          end
          default: ;
        endcase
      end
      phit[k]  = hit;
      pthit[k] = thit;
      if (wr_here) set_t[k] = wh * 60 + wm;
    end
  endtask

  function automatic logic [2*N:0] model_out();
    logic [N-1:0] r, e;
    for (int k = 0; k < N; k++) begin
      r[k] = (mode[k] == M_RING);
      e[k] = (mode[k] != M_OFF);
    end
    return {r, e, |r};
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [2*N:0] exp_v;
    logic [2*N:0] act_v;
    #1;
    if (sbq.size() > 0) begin
      exp_v = sbq.pop_front();
      act_v = {ringing_o, enabled_o, alarm_o};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL sb t=%0t: ring/en/alarm got=%b_%b_%b want=%b_%b_%b", $time,
                 act_v[2*N:N+1], act_v[N:1], act_v[0],
                 exp_v[2*N:N+1], exp_v[N:1], exp_v[0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(negedge clk);
    hour     = 5'(tod / 3600);
    minute   = 6'((tod / 60) % 60);
    second   = 6'(tod % 60);
    tick_1hz = tk;
    snooze_i = snz;
    stop_i   = stp;
    wr_en    = we;
    wr_idx   = 3'(widx);
    wr_hour  = 5'(wh);
    wr_min   = 6'(wm);
    toggle_i = tog;
    model_step();
    sbq.push_back(model_out());
    tk = 0; snz = 0; stp = 0; we = 0; tog = '0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    tod = h * 3600 + m * 60 + s;
    cycle();
  endtask

  task automatic tick_sec();
    tod = (tod + 1) % 86400;
    tk  = 1;
    cycle();
  endtask

  task automatic write_ch(input int idx, input int h, input int m);
    we = 1; widx = idx; wh = h; wm = m;
    cycle();
  endtask

  task automatic check1(input string name, input logic [N:0] got, input logic [N:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 0; tick_1hz = 0; hour = '0; minute = '0; second = '0;
    wr_en = 0; wr_idx = '0; wr_hour = '0; wr_min = '0; toggle_i = '0;
    snooze_i = 0; stop_i = 0;
    tod = 0; tk = 0; snz = 0; stp = 0; we = 0; widx = 0; wh = 0; wm = 0; tog = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check1("reset_ring_alarm", {ringing_o, alarm_o}, '0);
    check1("reset_enabled", {enabled_o, 1'b0}, '0);

    // basic ring on ch0 at 07:30
    write_ch(0, 7, 30);
    tog = 4'b0001; cycle();
    set_time(7, 29, 59);
    cycle();
    tick_sec();
    cycle();
    // stop at 07:30:10, minute 30 must stay silent
    repeat (9) tick_sec();
    tk = 1; tod = tod + 1; stp = 1; cycle();
    repeat (50) tick_sec();
    cycle();
    // next day same time rings again
    set_time(7, 29, 59);
    tick_sec();
    cycle();
    stp = 1; cycle();

    // snooze across midnight and snooze limit
    write_ch(0, 23, 58);
    set_time(23, 57, 59);
    tick_sec();
    repeat (20) tick_sec();
    snz = 1; cycle();
    cycle();
    set_time(0, 2, 59);
    tick_sec();
    cycle();
    snz = 1; cycle();
    set_time(0, 7, 59);
    tick_sec();
    snz = 1; cycle();
    set_time(0, 12, 59);
    tick_sec();
    cycle();
    snz = 1; cycle();
    repeat (2) cycle();

    // unattended ring times out
    write_ch(0, 10, 0);
    set_time(9, 59, 59);
    tick_sec();
    repeat (65) begin
      tick_sec();
      cycle();
    end

    // two channels together; stop and snooze in one cycle
    write_ch(1, 12, 0);
    write_ch(2, 12, 0);
    tog = 4'b0110; cycle();
    set_time(11, 59, 59);
    tick_sec();
    cycle();
    snz = 1; stp = 1; cycle();
    cycle();

    // out-of-range write indices are ignored
    write_ch(5, 12, 1);
    write_ch(4, 12, 1);
    set_time(12, 0, 59);
    tick_sec();
    repeat (2) cycle();

    // ch3 ringing then asynchronous reset mid-cycle
    write_ch(3, 13, 0);
    tog = 4'b1000; cycle();
    set_time(12, 59, 59);
    tick_sec();
    cycle();
    @(posedge clk);
    #3;
    check1("ring_before_reset", {ringing_o, alarm_o}, {4'b1000, 1'b1});
    rst_n = 0;
    #1;
    check1("async_reset_alarm", {ringing_o, alarm_o}, '0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #1;
    check1("post_reset_enabled", {enabled_o, 1'b0}, '0);
    set_time(11, 59, 59);
    tick_sec();
    repeat (3) cycle();

    // randomized traffic
    write_ch(0, 1, 2);
    tog = 4'b1111; cycle();
    tod = 3540;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom % 3 == 0) begin
        tod = tod + int'($urandom_range(1, 20));
        if (tod > 2 * 3600 + 300) tod = 3540;
        tk = 1;
      end
      for (int k = 0; k < N; k++)
        if ($urandom % 60 == 0) tog[k] = 1'b1;
      if ($urandom % 40 == 0) begin
        we = 1; widx = int'($urandom % 8);
        wh = int'($urandom_range(1, 2)); wm = int'($urandom_range(0, 4));
      end
      if ($urandom % 25 == 0) snz = 1;
      if ($urandom % 30 == 0) stp = 1;
      cycle();
    end

    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
